// File: rtl/key_event_conditioner.sv
// key_event_conditioner: turns four bouncy push-buttons into clean one-hot press
// events on a valid/ready interface. Chords of two or more keys are ignored
// until every key has been released.
module key_event_conditioner #(
  parameter int NUM_KEYS        = 4,       // the 2-bit code output holds 4 keys
  parameter int DEBOUNCE_CYCLES = 250000,  // 5 ms at 50 MHz; must be >= 1
  parameter bit ACTIVE_LOW      = 1'b1     // raw buttons read 0 when pressed
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] rawKey,
  input  logic                eventReady,
  output logic                eventValid,
  output logic [NUM_KEYS-1:0] eventKey,
  output logic [1:0]          eventCode,
  output logic [NUM_KEYS-1:0] keyLevel,
  output logic                releasePulse,
  output logic                multiError,
  output logic                overflow
);

  // The counter only ever needs to reach DEBOUNCE_CYCLES-1.
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    MULTI
  } state_t;

  logic [NUM_KEYS-1:0] key_norm;
  logic [NUM_KEYS-1:0] sync_meta;
  logic [NUM_KEYS-1:0] sync_key;
  logic [NUM_KEYS-1:0] db_key;
  logic [CNT_W-1:0]    cnt [NUM_KEYS];

  state_t              state_q, state_d;
  logic [NUM_KEYS-1:0] held_q, held_d;
  logic                ev_valid_q, ev_valid_d;
  logic [NUM_KEYS-1:0] ev_key_q, ev_key_d;
  logic [1:0]          ev_code_q, ev_code_d;
  logic                release_q, release_d;
  logic                multi_q, multi_d;
  logic                overflow_q, overflow_d;
  logic                press;
  logic                any_key;
  logic                single_key;

  // Binary index of a one-hot key vector.
  function automatic logic [1:0] key_index(input logic [NUM_KEYS-1:0] onehot);
    key_index = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (onehot[i]) key_index = 2'(i);
    end
  endfunction

  assign key_norm = ACTIVE_LOW ? ~rawKey : rawKey;

  // Two-flop synchroniser bringing the asynchronous buttons into the clock domain.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value; a blocking '=' here would collapse the two stages into one.
    if (reset) begin
      sync_meta <= '0;
      sync_key  <= '0;
    end else begin
      sync_meta <= key_norm;
      sync_key  <= sync_meta;
    end
  end

  // Per-key debounce: accept a change only after it persists for DEBOUNCE_CYCLES.
  always_ff @(posedge clock) begin
    // NOTE: the counter array is reset along with the levels so that a reset
    // in the middle of a debounce discards the partial count.
    if (reset) begin
      db_key <= '0;
      for (int i = 0; i < NUM_KEYS; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (sync_key[i] == db_key[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          db_key[i] <= sync_key[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign any_key    = |db_key;
  assign single_key = any_key && ((db_key & (db_key - NUM_KEYS'(1))) == '0);

  // Next-state, event register and status logic from the debounced levels.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    held_d     = held_q;
    press      = 1'b0;
    release_d  = 1'b0;
    ev_valid_d = ev_valid_q;
    ev_key_d   = ev_key_q;
    ev_code_d  = ev_code_q;
    overflow_d = overflow_q;

    unique case (state_q)
      IDLE: begin
        if (single_key) begin
          state_d = PRESSED;
          held_d  = db_key;
          press   = 1'b1;
        end else if (any_key) begin
          state_d = MULTI;
        end
      end
      PRESSED: begin
        if (db_key == held_q) begin
          state_d = PRESSED;
        end else if (!any_key) begin
          state_d   = IDLE;
          release_d = 1'b1;
        end else begin
          state_d = MULTI;
        end
      end
      MULTI: begin
        if (!any_key) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    multi_d = (state_d == MULTI);

    // Acceptance first, so a coinciding press can reload the register.
    if (ev_valid_q && eventReady) ev_valid_d = 1'b0;
    if (press) begin
      if (!ev_valid_q || eventReady) begin
        ev_valid_d = 1'b1;
        ev_key_d   = db_key;
        ev_code_d  = key_index(db_key);
      end else begin
        overflow_d = 1'b1;
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      held_q     <= '0;
      ev_valid_q <= 1'b0;
      ev_key_q   <= '0;
      ev_code_q  <= '0;
      release_q  <= 1'b0;
      multi_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      held_q     <= held_d;
      ev_valid_q <= ev_valid_d;
      ev_key_q   <= ev_key_d;
      ev_code_q  <= ev_code_d;
      release_q  <= release_d;
      multi_q    <= multi_d;
      overflow_q <= overflow_d;
    end
  end

  assign eventValid   = ev_valid_q;
  assign eventKey     = ev_key_q;
  assign eventCode    = ev_code_q;
  assign keyLevel     = db_key;
  assign releasePulse = release_q;
  assign multiError   = multi_q;
  assign overflow     = overflow_q;

endmodule
